// File: rtl/cpu_seq_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_seq_pkg                                            |
// | Description : T-state encoding and small next-state helpers shared  |
// |               by the machine-cycle / T-state sequencer.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_seq_pkg;

  // T-state codes as seen on the bus status encoder.
  typedef enum logic [2:0] {
    ST_WAIT = 3'b000,
    ST_T3   = 3'b001,
    ST_T1   = 3'b010,
    ST_STOP = 3'b011,
    ST_T2   = 3'b100,
    ST_T5   = 3'b101,
    ST_T1I  = 3'b110,
    ST_T4   = 3'b111
  } t_state_e;

  // State entered after an instruction ends: interrupt acknowledge or fetch.
  function automatic t_state_e end_next(input logic int_req);
    return int_req ? ST_T1I : ST_T1;
  endfunction

  // State following T2/WAIT: proceed to T3 once memory/IO is ready.
  function automatic t_state_e ready_next(input logic ready);
    return ready ? ST_T3 : ST_WAIT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_seq_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_seq_gen_if                                         |
// | Description : Decoder/bus-side signal bundle of the sequencer.       |
// |               Optional macro CPU_SEQ_SINGLE_STEP_EN adds STEP_MODE_I |
// |               and STEP_I.                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface cpu_seq_gen_if #(
  parameter int NCYC = 3
);
  localparam int CYC_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  logic             ADV_I;
  logic             READY_I;
  logic             INT_I;
  logic             HLT_I;
  logic             END_I;
  logic             EXT_I;
  logic             SKIP5_I;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic             STEP_MODE_I;
  logic             STEP_I;
`endif
  logic [2:0]       STATE_O;
  logic [CYC_W-1:0] CYCLE_O;
  logic             DONE_O;
  logic             ERR_O;

  // Decoder / control side.
  modport master (
    output ADV_I, READY_I, INT_I, HLT_I, END_I, EXT_I, SKIP5_I,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    output STEP_MODE_I, STEP_I,
`endif
    input  STATE_O, CYCLE_O, DONE_O, ERR_O
  );

  // Sequencer side.
  modport slave (
    input  ADV_I, READY_I, INT_I, HLT_I, END_I, EXT_I, SKIP5_I,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  STEP_MODE_I, STEP_I,
`endif
    output STATE_O, CYCLE_O, DONE_O, ERR_O
  );

endinterface
`default_nettype wire

// File: rtl/cpu_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_seq_gen                                            |
// | Description : Descriptor-driven machine-cycle / T-state sequencer    |
// |               with READY waits, halt/interrupt restart, end strobe   |
// |               and sticky descriptor-overrun flag.                    |
// |               Optional macro CPU_SEQ_SINGLE_STEP_EN: single-step.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cpu_seq_gen
  import cpu_seq_pkg::*;
#(
  parameter int NCYC = 3
) (
  input  wire logic     CLK_I,
  input  wire logic     RST_I,
  cpu_seq_gen_if.slave  bus
);

  localparam int               CYC_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CYC_W-1:0] c_last = CYC_W'(NCYC - 1);
  localparam logic [CYC_W-1:0] c_one  = CYC_W'(1);

  t_state_e         r_state;
  t_state_e         w_state_nxt;
  logic [CYC_W-1:0] r_cyc;
  logic [CYC_W-1:0] w_cyc_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_finish;

  // Next-state decode; decoder inputs only matter in T3/T4.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_finish    = 1'b0;
    if (bus.ADV_I) begin
      case (r_state)
        ST_T1, ST_T1I: w_state_nxt = ST_T2;
        ST_T2, ST_WAIT: w_state_nxt = ready_next(bus.READY_I);
        ST_T3: begin
          if (r_cyc == '0 && bus.HLT_I) begin
            w_state_nxt = ST_STOP;
          end else if (bus.END_I) begin
            w_finish = 1'b1;
          end else if (bus.EXT_I) begin
            w_state_nxt = ST_T4;
          end else if (r_cyc < c_last) begin
            w_state_nxt = ST_T1;
            w_cyc_nxt   = r_cyc + c_one;
          end else begin
            // Descriptor asked for more cycles than the sequencer supports.
            w_finish  = 1'b1;
            w_err_nxt = 1'b1;
          end
        end
        ST_T4: begin
          if (bus.SKIP5_I) begin
            if (r_cyc < c_last) begin
              w_state_nxt = ST_T1;
              w_cyc_nxt   = r_cyc + c_one;
            end else begin
              w_finish  = 1'b1;
              w_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ST_T5;
          end
        end
        ST_T5: w_finish = 1'b1;
        ST_STOP: begin
          if (bus.INT_I) begin
            w_state_nxt = ST_T1I;
            w_cyc_nxt   = '0;
          end
`ifdef CPU_SEQ_SINGLE_STEP_EN
          else if (bus.STEP_I) begin
            w_state_nxt = ST_T1;
            w_cyc_nxt   = '0;
          end
`endif
        end
        default: begin
          w_state_nxt = ST_T1;
          w_cyc_nxt   = '0;
        end
      endcase
      if (w_finish) begin
        w_done_nxt  = 1'b1;
        w_cyc_nxt   = '0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        w_state_nxt = bus.STEP_MODE_I ? ST_STOP : end_next(bus.INT_I);
`else
        w_state_nxt = end_next(bus.INT_I);
`endif
      end
    end
  end

  // State, cycle counter and registered outputs; reset abandons any instruction.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= ST_T1;
      r_cyc   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.STATE_O = r_state;
  assign bus.CYCLE_O = r_cyc;
  assign bus.DONE_O  = r_done;
  assign bus.ERR_O   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cpu_seq_gen                                         |
// | Description : Self-checking bench for cpu_seq_gen (NCYC=3 and 2)     |
// |               with a phase-level reference model.                    |
// |               Honours macro CPU_SEQ_SINGLE_STEP_EN.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_cpu_seq_gen;

  localparam logic [2:0] S_WAIT = 3'b000, S_T3 = 3'b001, S_T1 = 3'b010, S_STOP = 3'b011;
  localparam logic [2:0] S_T2 = 3'b100, S_T5 = 3'b101, S_T1I = 3'b110, S_T4 = 3'b111;

  localparam int P_T1 = 0, P_T1I = 1, P_T2 = 2, P_WAIT = 3, P_T3 = 4, P_T4 = 5, P_T5 = 6, P_STOP = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, adv, ready, intr, hlt, endi, ext, skip5;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step_mode, step;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  cpu_seq_gen_if #(.NCYC(3)) bus_a();
  cpu_seq_gen_if #(.NCYC(2)) bus_b();

  assign bus_a.ADV_I = adv;   assign bus_b.ADV_I = adv;
  assign bus_a.READY_I = ready; assign bus_b.READY_I = ready;
  assign bus_a.INT_I = intr;  assign bus_b.INT_I = intr;
  assign bus_a.HLT_I = hlt;   assign bus_b.HLT_I = hlt;
  assign bus_a.END_I = endi;  assign bus_b.END_I = endi;
  assign bus_a.EXT_I = ext;   assign bus_b.EXT_I = ext;
  assign bus_a.SKIP5_I = skip5; assign bus_b.SKIP5_I = skip5;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign bus_a.STEP_MODE_I = step_mode; assign bus_b.STEP_MODE_I = step_mode;
  assign bus_a.STEP_I = step; assign bus_b.STEP_I = step;
`endif

  cpu_seq_gen #(.NCYC(3)) u_dut_a (.CLK_I(clk), .RST_I(rst), .bus(bus_a));
  cpu_seq_gen #(.NCYC(2)) u_dut_b (.CLK_I(clk), .RST_I(rst), .bus(bus_b));

  // Reference model: phase name, cycle index, strobe and error per instance.
  logic [2:0] code_tbl [8] = '{S_T1, S_T1I, S_T2, S_WAIT, S_T3, S_T4, S_T5, S_STOP};
  int m_n   [2] = '{3, 2};
  int m_ph  [2];
  int m_cyc [2];
  bit m_done[2];
  bit m_err [2];

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit fin;
      fin = 1'b0;
      if (rst) begin
        m_ph[k] = P_T1; m_cyc[k] = 0; m_done[k] = 1'b0; m_err[k] = 1'b0;
      end else begin
        m_done[k] = 1'b0;
        if (adv) begin
          case (m_ph[k])
            P_T1, P_T1I: m_ph[k] = P_T2;
            P_T2, P_WAIT: m_ph[k] = ready ? P_T3 : P_WAIT;
            P_T3: begin
              if (m_cyc[k] == 0 && hlt) m_ph[k] = P_STOP;
              else if (endi) fin = 1'b1;
              else if (ext) m_ph[k] = P_T4;
              else if (m_cyc[k] < m_n[k] - 1) begin m_ph[k] = P_T1; m_cyc[k]++; end
              else begin fin = 1'b1; m_err[k] = 1'b1; end
            end
            P_T4: begin
              if (!skip5) m_ph[k] = P_T5;
              else if (m_cyc[k] < m_n[k] - 1) begin m_ph[k] = P_T1; m_cyc[k]++; end
              else begin fin = 1'b1; m_err[k] = 1'b1; end
            end
            P_T5: fin = 1'b1;
            default: begin
              if (intr) begin m_ph[k] = P_T1I; m_cyc[k] = 0; end
`ifdef CPU_SEQ_SINGLE_STEP_EN
              else if (step) begin m_ph[k] = P_T1; m_cyc[k] = 0; end
`endif
            end
          endcase
          if (fin) begin
            m_done[k] = 1'b1;
            m_cyc[k]  = 0;
            m_ph[k]   = intr ? P_T1I : P_T1;
`ifdef CPU_SEQ_SINGLE_STEP_EN
            if (step_mode) m_ph[k] = P_STOP;
`endif
          end
        end
      end
    end
  endtask

  // One clock: DUT and model see the same inputs; outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  function automatic logic [6:0] va(logic [2:0] s, int c, bit d, bit e);
    return {s, 2'(c), d, e};
  endfunction

  function automatic logic [5:0] vb(logic [2:0] s, int c, bit d, bit e);
    return {s, 1'(c), d, e};
  endfunction

  task automatic idle_inputs();
    adv = 1'b1; ready = 1'b1; intr = 1'b0; hlt = 1'b0; endi = 1'b0; ext = 1'b0; skip5 = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] oa;
    logic [5:0] ob;
    idle_inputs();
    do_reset();
    oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
    ob = {bus_b.STATE_O, bus_b.CYCLE_O, bus_b.DONE_O, bus_b.ERR_O};
    n_chk++;
    if (oa !== va(S_T1, 0, 0, 0)) $display("FAIL reset_a got=%b exp=%b", oa, va(S_T1, 0, 0, 0));
    else n_pass++;
    n_chk++;
    if (ob !== vb(S_T1, 0, 0, 0)) $display("FAIL reset_b got=%b exp=%b", ob, vb(S_T1, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_nop();
    logic [6:0] ev [6];
    logic [6:0] oa;
    ev = '{va(S_T2,0,0,0), va(S_T3,0,0,0), va(S_T1,0,1,0),
           va(S_T2,0,0,0), va(S_T3,0,0,0), va(S_T1,0,1,0)};
    idle_inputs(); endi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
      n_chk++;
      if (oa !== ev[i]) $display("FAIL nop step%0d got=%b exp=%b", i, oa, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wait();
    bit         sa [8];
    bit         sr [8];
    logic [6:0] ev [8];
    logic [6:0] oa;
    sa = '{1, 0, 0, 0, 0, 0, 1, 1};
    sr = '{1, 0, 0, 0, 0, 0, 1, 1};
    ev = '{va(S_T2,0,0,0), va(S_WAIT,0,0,0), va(S_WAIT,0,0,0), va(S_WAIT,0,0,0),
           va(S_WAIT,0,0,0), va(S_WAIT,0,0,0), va(S_T3,0,0,0), va(S_T1,0,1,0)};
    // ADV low on steps 4,5 (hold); READY low for three ADV clocks.
    sa[1] = 1; sa[2] = 1; sa[3] = 1;
    idle_inputs(); endi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      adv = sa[i]; ready = sr[i];
      tick();
      oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
      n_chk++;
      if (oa !== ev[i]) $display("FAIL wait step%0d got=%b exp=%b", i, oa, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_multi_cycle();
    logic [6:0] ev [12];
    logic [6:0] oa;
    ev = '{va(S_T2,0,0,0), va(S_T3,0,0,0), va(S_T1,1,0,0), va(S_T2,1,0,0),
           va(S_T3,1,0,0), va(S_T1,2,0,0), va(S_T2,2,0,0), va(S_T3,2,0,0),
           va(S_T4,2,0,0), va(S_T5,2,0,0), va(S_T1,0,1,0), va(S_T2,0,0,0)};
    idle_inputs();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ext = (i == 8);
      tick();
      oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
      n_chk++;
      if (oa !== ev[i]) $display("FAIL multi step%0d got=%b exp=%b", i, oa, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_skip5_overrun();
    logic [6:0] ev [13];
    logic [6:0] oa;
    ev = '{va(S_T2,0,0,0), va(S_T3,0,0,0), va(S_T4,0,0,0), va(S_T1,1,0,0),
           va(S_T2,1,0,0), va(S_T3,1,0,0), va(S_T4,1,0,0), va(S_T1,2,0,0),
           va(S_T2,2,0,0), va(S_T3,2,0,0), va(S_T4,2,0,0), va(S_T1,0,1,1),
           va(S_T2,0,0,1)};
    idle_inputs();
    do_reset();
    ext = 1'b1; skip5 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
      n_chk++;
      if (oa !== ev[i]) $display("FAIL skip5 step%0d got=%b exp=%b", i, oa, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    logic [6:0] oa;
    idle_inputs();
    do_reset();
    hlt = 1'b1;
    tick(); tick(); tick();
    hlt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adv = (i % 3) != 2;
      tick();
      oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
      n_chk++;
      if (oa !== va(S_STOP,0,0,0)) $display("FAIL halt_hold%0d got=%b exp=%b", i, oa, va(S_STOP,0,0,0));
      else n_pass++;
    end
    adv = 1'b1; intr = 1'b1;
    tick();
    oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
    n_chk++;
    if (oa !== va(S_T1I,0,0,0)) $display("FAIL halt_int got=%b exp=%b", oa, va(S_T1I,0,0,0));
    else n_pass++;
    intr = 1'b0;
    tick();
    oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
    n_chk++;
    if (oa !== va(S_T2,0,0,0)) $display("FAIL halt_t2 got=%b exp=%b", oa, va(S_T2,0,0,0));
    else n_pass++;
  endtask

  task automatic test_overrun_ncyc2();
    logic [5:0] ev [10];
    logic [5:0] ob;
    ev = '{vb(S_T2,0,0,0), vb(S_T3,0,0,0), vb(S_T1,1,0,0), vb(S_T2,1,0,0),
           vb(S_T3,1,0,0), vb(S_T1,0,1,1), vb(S_T2,0,0,1), vb(S_T3,0,0,1),
           vb(S_T1,0,1,1), vb(S_T2,0,0,1)};
    idle_inputs();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      endi = (i >= 6);
      tick();
      ob = {bus_b.STATE_O, bus_b.CYCLE_O, bus_b.DONE_O, bus_b.ERR_O};
      n_chk++;
      if (ob !== ev[i]) $display("FAIL overrun step%0d got=%b exp=%b", i, ob, ev[i]);
      else n_pass++;
    end
    do_reset();
    ob = {bus_b.STATE_O, bus_b.CYCLE_O, bus_b.DONE_O, bus_b.ERR_O};
    n_chk++;
    if (ob !== vb(S_T1,0,0,0)) $display("FAIL overrun_clear got=%b exp=%b", ob, vb(S_T1,0,0,0));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [6:0] oa;
    idle_inputs();
    do_reset();
    tick(); tick(); tick();
    ready = 1'b0;
    tick(); tick(); tick();
    oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
    n_chk++;
    if (oa !== va(S_WAIT,1,0,0)) $display("FAIL mid_wait got=%b exp=%b", oa, va(S_WAIT,1,0,0));
    else n_pass++;
    endi = 1'b1; ready = 1'b1;
    do_reset();
    oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
    n_chk++;
    if (oa !== va(S_T1,0,0,0)) $display("FAIL mid_reset got=%b exp=%b", oa, va(S_T1,0,0,0));
    else n_pass++;
  endtask

`ifdef CPU_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    logic [6:0] ev [5];
    logic [6:0] oa;
    ev = '{va(S_T2,0,0,0), va(S_T3,0,0,0), va(S_STOP,0,1,0), va(S_STOP,0,0,0), va(S_T1,0,0,0)};
    idle_inputs();
    do_reset();
    step_mode = 1'b1; endi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step = (i == 4);
      tick();
      oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
      n_chk++;
      if (oa !== ev[i]) $display("FAIL step step%0d got=%b exp=%b", i, oa, ev[i]);
      else n_pass++;
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic [6:0] oa, ea;
    logic [5:0] ob, eb;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(63) == 0);
      adv   = ($urandom_range(3) != 0);
      ready = ($urandom_range(2) != 0);
      intr  = ($urandom_range(7) == 0);
      hlt   = ($urandom_range(5) == 0);
      endi  = ($urandom_range(2) == 0);
      ext   = 1'($urandom);
      skip5 = 1'($urandom);
`ifdef CPU_SEQ_SINGLE_STEP_EN
      step_mode = ($urandom_range(3) == 0);
      step      = ($urandom_range(3) == 0);
`endif
      tick();
      oa = {bus_a.STATE_O, bus_a.CYCLE_O, bus_a.DONE_O, bus_a.ERR_O};
      ea = {code_tbl[m_ph[0]], 2'(m_cyc[0]), m_done[0], m_err[0]};
      ob = {bus_b.STATE_O, bus_b.CYCLE_O, bus_b.DONE_O, bus_b.ERR_O};
      eb = {code_tbl[m_ph[1]], 1'(m_cyc[1]), m_done[1], m_err[1]};
      n_chk++;
      if (oa !== ea) $display("FAIL rand_a clk%0d got=%b exp=%b", i, oa, ea);
      else n_pass++;
      n_chk++;
      if (ob !== eb) $display("FAIL rand_b clk%0d got=%b exp=%b", i, ob, eb);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_ph = '{P_T1, P_T1}; m_cyc = '{0, 0}; m_done = '{0, 0}; m_err = '{0, 0};
    test_reset();
    test_nop();
    test_wait();
    test_multi_cycle();
    test_skip5_overrun();
    test_halt();
    test_overrun_ncyc2();
    test_reset_mid();
`ifdef CPU_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
